md_unit_ctrl: RTL and testbench
===============================

Name: md_unit_ctrl

Overview:
Multiply/divide unit with its own sequencer, instantiated in the Execute stage beside the ALU. It accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo operations and runs the multi-cycle ones for a fixed latency. It owns the HI/LO registers and produces the start/busy pair that the hazard unit uses to stall later mult/div-family instructions in Decode. An E-stage flush from exception/interrupt handling cancels an operation before it starts.

Parameters:
MULT_CYCLES, 5, busy duration for mult/multu (and madd family), range 1..15
DIV_CYCLES, 10, busy duration for div/divu, range 1..15

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
md_op  input  4  E-stage operation code (md_op_e encoding in package); MD_NONE when idle
flush  input  1  E-stage instruction cancelled this cycle (exception/interrupt in M); blocks start and HI/LO writes
A  input  32  rs operand, already forwarded
B  input  32  rt operand, already forwarded
start  output  1  combinational; mult/div accepted this cycle
busy  output  1  registered; operation in progress
hi  output  32  current HI
lo  output  32  current LO
md_out  output  32  HI for MD_MFHI, LO for MD_MFLO, else 0

Behaviour:
- Reset: state IDLE, cnt=0, HI=LO=0, pending results=0; busy=0; start=0 unless a valid op is presented (start is combinational).
- States: IDLE, RUN. Counter cnt is 4 bits.
- start = (state==IDLE) & ~flush & md_op in {MULT,MULTU,DIV,DIVU}, plus the madd family when the optional feature is compiled in.
- On the start edge:
  - Compute the result and hold it in pend_hi/pend_lo.
  - Go to RUN with cnt = MULT_CYCLES-1 or DIV_CYCLES-1.
  - busy rises the next cycle.
- RUN:
  - busy=1 for exactly MULT_CYCLES or DIV_CYCLES cycles.
  - cnt decrements each cycle.
  - At the edge where cnt==0: HI<=pend_hi, LO<=pend_lo, go to IDLE; busy=0 from the next cycle.
  - Back-to-back ops are possible: a new start may occur in the first cycle busy=0.
- Arithmetic:
  - mult: {HI,LO} = signed 64-bit product. multu: unsigned 64-bit product.
  - div: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend. divu: unsigned quotient and remainder.
  - Divide by zero: HI/LO are left unchanged, but busy still runs DIV_CYCLES.
- mthi/mtlo: write HI/LO at the edge when state==IDLE and ~flush; no busy.
- mfhi/mflo: md_out is combinational from the current HI/LO.
- An md op presented while RUN (hazard-unit protocol violation) is ignored; the bench asserts it never happens.
- flush while RUN does not abort; an operation already started always completes.
- reset mid-operation: immediate return to IDLE, busy=0, HI/LO=0, pending result discarded.

Optional Feature:
MDU_MADD_EN
- Defined: accepts MD_MADD/MADDU/MSUB/MSUBU.
  - {HI,LO} is updated by +/- the signed or unsigned product (64-bit wrap).
  - Accumulation is computed from HI/LO at completion.
  - Busy duration is MULT_CYCLES.
- Undefined: these codes behave as MD_NONE, with no start, busy or write.

Decomposition:
- Shared package md_pkg holds:
  - md_op_e: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12.
  - Default cycle-count constants.
- The hazard unit imports md_pkg too.
- One sub-module, md_arith: combinational product/quotient/remainder from A, B and op. The sequencer and HI/LO stay in md_unit_ctrl.

Test Plan:
- mult A=3, B=0xFFFFFFFC: start=1 for 1 cycle, then busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF4.
- divu A=7, B=2: busy for 10 cycles, then HI=1, LO=3; div A=0xFFFFFFF9 (-7), B=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- mult with flush=1 in the same cycle: start=0, busy stays 0, HI/LO unchanged; mthi 0x1234 with flush=1: HI unchanged.
- mthi A=0xDEADBEEF, next cycle md_op=MFHI: md_out=0xDEADBEEF; mtlo then mflo: same check for LO.
- div started, reset asserted in busy cycle 4: busy=0 and HI=LO=0 immediately; no later commit.
- div by B=0 with HI=5, LO=6: busy for 10 cycles, HI=5 and LO=6 afterward; with MDU_MADD_EN, HI=0, LO=10, madd 3×4: LO=22.

Source files
------------

// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: operation codes and default latencies.
// Also imported by the hazard unit so both sides agree on the op encoding.
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10,
        MD_MSUB  = 4'd11,
        MD_MSUBU = 4'd12
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_arith.sv
// Combinational product / quotient / remainder for the multiply-divide unit.
// Division by zero yields a flag only; the sequencer suppresses the HI/LO write.
module md_arith
    import md_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic [63:0] prod_s, prod_u;
    logic [31:0] dvsr, quo_s, rem_s, quo_u, rem_u;

    always_comb begin
        div_zero = (b == 32'd0);
        // Substitute a harmless divisor so the divider never sees zero.
        dvsr     = div_zero ? 32'd1 : b;
        prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u   = {32'd0, a} * {32'd0, b};
        quo_s    = $signed(a) / $signed(dvsr);
        rem_s    = $signed(a) % $signed(dvsr);
        quo_u    = a / dvsr;
        rem_u    = a % dvsr;
        res_hi   = 32'd0;
        res_lo   = 32'd0;
        case (op)
            MD_MULT,  MD_MADD,  MD_MSUB:  {res_hi, res_lo} = prod_s;
            MD_MULTU, MD_MADDU, MD_MSUBU: {res_hi, res_lo} = prod_u;
            MD_DIV:  begin res_hi = rem_s; res_lo = quo_s; end
            MD_DIVU: begin res_hi = rem_u; res_lo = quo_u; end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer owning HI/LO; fixed-latency busy window for the hazard unit.
// Optional MDU_MADD_EN adds madd/maddu/msub/msubu accumulate operations.
module md_unit_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic        flush,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        commit;
    logic        is_mul, is_div, is_acc, acc_sub;
    logic [31:0] res_hi, res_lo;
    logic        div_zero;
    logic [31:0] pend_hi, pend_lo;
    logic        pend_wr, pend_acc, pend_sub;

    md_arith u_arith (
        .op       (md_op),
        .a        (A),
        .b        (B),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    always_comb begin
        is_mul  = (md_op == MD_MULT) || (md_op == MD_MULTU);
        is_div  = (md_op == MD_DIV)  || (md_op == MD_DIVU);
        is_acc  = 1'b0;
        acc_sub = 1'b0;
`ifdef MDU_MADD_EN
        if (md_op inside {MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU}) begin
            is_mul  = 1'b1;
            is_acc  = 1'b1;
            acc_sub = (md_op == MD_MSUB) || (md_op == MD_MSUBU);
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                state_nxt = S_RUN;
                cnt_nxt   = is_div ? 4'(DIV_CYCLES - 1) : 4'(MULT_CYCLES - 1);
            end
            S_RUN: if (cnt == 4'd0) begin
                state_nxt = S_IDLE;
                commit    = 1'b1;
            end else begin
                cnt_nxt = cnt - 4'd1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        start  = (state == S_IDLE) && !flush && (is_mul || is_div);
        busy   = (state == S_RUN);
        md_out = 32'd0;
        if (md_op == MD_MFHI)      md_out = hi;
        else if (md_op == MD_MFLO) md_out = lo;
    end

    // Result is latched at start; accumulate ops fold into HI/LO only at completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi       <= 32'd0;
            lo       <= 32'd0;
            pend_hi  <= 32'd0;
            pend_lo  <= 32'd0;
            pend_wr  <= 1'b0;
            pend_acc <= 1'b0;
            pend_sub <= 1'b0;
        end else begin
            if (start) begin
                pend_hi  <= res_hi;
                pend_lo  <= res_lo;
                pend_wr  <= !(is_div && div_zero);
                pend_acc <= is_acc;
                pend_sub <= acc_sub;
            end
            if (commit) begin
                if (pend_wr) begin
                    if (pend_acc && pend_sub)
                        {hi, lo} <= {hi, lo} - {pend_hi, pend_lo};
                    else if (pend_acc)
                        {hi, lo} <= {hi, lo} + {pend_hi, pend_lo};
                    else
                        {hi, lo} <= {pend_hi, pend_lo};
                end
            end else if (state == S_IDLE && !flush) begin
                if (md_op == MD_MTHI) hi <= A;
                if (md_op == MD_MTLO) lo <= A;
            end
        end
    end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed self-checking bench for md_unit_ctrl (default latencies 5/10).
// Inputs change on the falling edge; outputs are sampled shortly after it.
module tb_md_unit_ctrl;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  md_op;
    logic        flush;
    logic [31:0] A, B;
    logic        start, busy;
    logic [31:0] hi, lo, md_out;

    int errors = 0;
    int checks = 0;

    md_unit_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .md_op  (md_op),
        .flush  (flush),
        .A      (A),
        .B      (B),
        .start  (start),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .md_out (md_out)
    );

    always #5 clk = ~clk;

    // Hazard-unit contract: no mult/div-family op may reach E while busy.
    always @(posedge clk) begin
        if (!reset && busy && md_op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
                                            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU}) begin
            errors++;
            $display("FAIL protocol: op %0d presented while busy", md_op);
        end
    end

    // Called just after a falling edge; returns after the first idle falling edge.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic st, output int n);
        md_op = op; A = a; B = b;
        #1 st = start;
        @(negedge clk);
        md_op = MD_NONE; A = 32'd0; B = 32'd0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic write_hl(input logic [31:0] h, input logic [31:0] l);
        md_op = MD_MTHI; A = h;
        @(negedge clk);
        md_op = MD_MTLO; A = l;
        @(negedge clk);
        md_op = MD_NONE; A = 32'd0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start_idle: got %b want 0", start); end
        md_op = MD_MULT;
        #1;
        checks++; if (start !== 1'b1) begin errors++; $display("FAIL reset_start_comb: got %b want 1", start); end
        md_op = MD_NONE;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mult();
        logic st; int n;
        run_op(MD_MULT, 32'd3, 32'hFFFF_FFFC, st, n);
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL mult_start: got %b want 1", st); end
        checks++; if (n != 5) begin errors++; $display("FAIL mult_busy_cycles: got %0d want 5", n); end
        checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF4)
            begin errors++; $display("FAIL mult_result: got %h want ffffffff_fffffff4", {hi, lo}); end
    endtask

    task automatic test_div();
        logic st; int n;
        run_op(MD_DIVU, 32'd7, 32'd2, st, n);
        checks++; if (n != 10) begin errors++; $display("FAIL divu_busy_cycles: got %0d want 10", n); end
        checks++; if ({hi, lo} !== {32'd1, 32'd3})
            begin errors++; $display("FAIL divu_result: got %h want 00000001_00000003", {hi, lo}); end
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, st, n);
        checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD)
            begin errors++; $display("FAIL div_neg_dividend: got %h want ffffffff_fffffffd", {hi, lo}); end
        run_op(MD_DIV, 32'd7, 32'hFFFF_FFFE, st, n);
        checks++; if ({hi, lo} !== {32'd1, 32'hFFFF_FFFD})
            begin errors++; $display("FAIL div_neg_divisor: got %h want 00000001_fffffffd", {hi, lo}); end
    endtask

    task automatic test_flush();
        logic st; int n;
        write_hl(32'h1111_2222, 32'h3333_4444);
        flush = 1'b1;
        run_op(MD_MULT, 32'd5, 32'd6, st, n);
        checks++; if (st !== 1'b0) begin errors++; $display("FAIL flush_start: got %b want 0", st); end
        checks++; if (n != 0) begin errors++; $display("FAIL flush_busy: got %0d cycles want 0", n); end
        md_op = MD_MTHI; A = 32'h1234;
        @(negedge clk);
        md_op = MD_NONE; A = 32'd0; flush = 1'b0;
        #1;
        checks++; if ({hi, lo} !== 64'h1111_2222_3333_4444)
            begin errors++; $display("FAIL flush_hilo: got %h want 11112222_33334444", {hi, lo}); end
        @(negedge clk);
    endtask

    task automatic test_mfhi_mflo();
        md_op = MD_MTHI; A = 32'hDEAD_BEEF;
        @(negedge clk);
        md_op = MD_MFHI; A = 32'd0;
        #1;
        checks++; if (md_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mfhi: got %h want deadbeef", md_out); end
        @(negedge clk);
        md_op = MD_MTLO; A = 32'hCAFE_F00D;
        @(negedge clk);
        md_op = MD_MFLO; A = 32'd0;
        #1;
        checks++; if (md_out !== 32'hCAFE_F00D) begin errors++; $display("FAIL mflo: got %h want cafef00d", md_out); end
        md_op = MD_NONE;
        #1;
        checks++; if (md_out !== 32'd0) begin errors++; $display("FAIL md_out_none: got %h want 0", md_out); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic st; int n;
        run_op(MD_MULT, 32'd3, 32'd4, st, n);
        checks++; if ({hi, lo} !== 64'd12) begin errors++; $display("FAIL b2b_first: got %h want 0000000c", {hi, lo}); end
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, st, n);
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL b2b_start: got %b want 1", st); end
        checks++; if ({hi, lo} !== {32'd1, 32'hFFFF_FFFE})
            begin errors++; $display("FAIL multu_result: got %h want 00000001_fffffffe", {hi, lo}); end
    endtask

    task automatic test_div_zero();
        logic st; int n;
        write_hl(32'd5, 32'd6);
        run_op(MD_DIV, 32'd100, 32'd0, st, n);
        checks++; if (n != 10) begin errors++; $display("FAIL divz_busy_cycles: got %0d want 10", n); end
        checks++; if ({hi, lo} !== {32'd5, 32'd6})
            begin errors++; $display("FAIL divz_hilo: got %h want 00000005_00000006", {hi, lo}); end
    endtask

    task automatic test_madd();
        logic st; int n;
        write_hl(32'd0, 32'd10);
`ifdef MDU_MADD_EN
        run_op(MD_MADD, 32'd3, 32'd4, st, n);
        checks++; if (n != 5) begin errors++; $display("FAIL madd_busy_cycles: got %0d want 5", n); end
        checks++; if ({hi, lo} !== 64'd22) begin errors++; $display("FAIL madd_result: got %h want 22", {hi, lo}); end
        run_op(MD_MSUB, 32'd2, 32'd3, st, n);
        checks++; if ({hi, lo} !== 64'd16) begin errors++; $display("FAIL msub_result: got %h want 16", {hi, lo}); end
`else
        run_op(MD_MADD, 32'd3, 32'd4, st, n);
        checks++; if (st !== 1'b0) begin errors++; $display("FAIL madd_off_start: got %b want 0", st); end
        checks++; if (n != 0) begin errors++; $display("FAIL madd_off_busy: got %0d want 0", n); end
        checks++; if ({hi, lo} !== 64'd10) begin errors++; $display("FAIL madd_off_hilo: got %h want 10", {hi, lo}); end
`endif
    endtask

    task automatic test_reset_mid_op();
        logic st; int n;
        write_hl(32'hAAAA_0000, 32'h0000_BBBB);
        md_op = MD_DIV; A = 32'd50; B = 32'd7;
        @(negedge clk);
        md_op = MD_NONE; A = 32'd0; B = 32'd0;
        // Busy cycle 1 now; advance to busy cycle 4.
        repeat (3) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_busy: got %b want 1", busy); end
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL rst_mid_hilo: got %h want 0", {hi, lo}); end
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if ({busy, hi, lo} !== 65'd0)
            begin errors++; $display("FAIL rst_no_commit: got busy=%b hilo=%h want 0", busy, {hi, lo}); end
    endtask

    initial begin
        reset = 1'b1; md_op = MD_NONE; flush = 1'b0; A = 32'd0; B = 32'd0;
        test_reset();
        test_mult();
        test_div();
        test_flush();
        test_mfhi_mflo();
        test_back_to_back();
        test_div_zero();
        test_madd();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
